// File: rtl/axi_host_mem_responder.sv
// axi_host_mem_responder: AXI4 slave backed by a byte-enabled RAM that stands in for host memory
// Ports: clk, rst_n (sync, active-low); AW/W/B write channels and AR/R read channels of an
// AXI4 slave. Bursts are full-width INCR only, with one outstanding burst per direction.
// The request ID is echoed on B and R. Out-of-range or miscounted beats answer SLVERR.
module axi_host_mem_responder #(
    parameter int                    ID_WIDTH       = 5,
    parameter int                    ADDR_WIDTH     = 64,
    parameter int                    DATA_WIDTH     = 512,
    parameter int                    MEM_DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(NB);
    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(1) << MEM_DEPTH_LOG2;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_DATA} rd_state_t;
    logic [DATA_WIDTH-1:0] mem [2**MEM_DEPTH_LOG2];
    wr_state_t wr_state;
    rd_state_t rd_state;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
    logic wr_under, rd_under, wr_err, wr_in, rd_in, wr_fire, wr_beat_err;
    logic [7:0] wr_len, rd_len, rd_cnt;
    logic [8:0] wr_cnt;
    always_comb begin
        wr_in = !wr_under && wr_idx < DEPTH;
        rd_in = !rd_under && rd_idx < DEPTH;
        wr_fire = s_wvalid && s_wready;
        // beats past len+1 are counted as errors and never reach the RAM
        wr_beat_err = !wr_in || wr_cnt > {1'b0, wr_len};
    end
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire && !wr_beat_err)
            for (int i = 0; i < NB; i++)
                if (s_wstrb[i])
                    mem[wr_idx[MEM_DEPTH_LOG2-1:0]][i*8 +: 8] <= s_wdata[i*8 +: 8];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state  <= WR_IDLE;
            s_awready <= 1'b1;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bid     <= '0;
            s_bresp   <= OKAY;
            wr_idx    <= '0;
            wr_under  <= 1'b0;
            wr_len    <= '0;
            wr_cnt    <= '0;
            wr_err    <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: if (s_awvalid) begin
                    s_bid     <= s_awid;
                    wr_idx    <= (s_awaddr - BASE_ADDR) >> SHIFT;
                    wr_under  <= s_awaddr < BASE_ADDR;
                    wr_len    <= s_awlen;
                    wr_cnt    <= '0;
                    wr_err    <= 1'b0;
                    s_awready <= 1'b0;
                    s_wready  <= 1'b1;
                    wr_state  <= WR_DATA;
                end
                WR_DATA: if (s_wvalid) begin
                    wr_idx <= wr_idx + 1'b1;
                    wr_cnt <= wr_cnt + 9'd1;
                    wr_err <= wr_err || wr_beat_err;
                    if (s_wlast) begin
                        s_wready <= 1'b0;
                        s_bvalid <= 1'b1;
                        s_bresp  <= (wr_err || wr_beat_err || wr_cnt != {1'b0, wr_len}) ? SLVERR : OKAY;
                        wr_state <= WR_RESP;
                    end
                end
                WR_RESP: if (s_bready) begin
                    s_bvalid  <= 1'b0;
                    s_awready <= 1'b1;
                    wr_state  <= WR_IDLE;
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state  <= RD_IDLE;
            s_arready <= 1'b1;
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_rid     <= '0;
            s_rresp   <= OKAY;
            s_rdata   <= '0;
            rd_idx    <= '0;
            rd_under  <= 1'b0;
            rd_len    <= '0;
            rd_cnt    <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: if (s_arvalid) begin
                    s_rid     <= s_arid;
                    rd_idx    <= (s_araddr - BASE_ADDR) >> SHIFT;
                    rd_under  <= s_araddr < BASE_ADDR;
                    rd_len    <= s_arlen;
                    rd_cnt    <= '0;
                    s_arready <= 1'b0;
                    rd_state  <= RD_FETCH;
                end
                RD_FETCH: begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= rd_in ? mem[rd_idx[MEM_DEPTH_LOG2-1:0]] : '0;
                    s_rresp  <= rd_in ? OKAY : SLVERR;
                    s_rlast  <= rd_cnt == rd_len;
                    rd_state <= RD_DATA;
                end
                RD_DATA: if (s_rready) begin
                    s_rvalid <= 1'b0;
                    s_rlast  <= 1'b0;
                    rd_idx   <= rd_idx + 1'b1;
                    rd_cnt   <= rd_cnt + 8'd1;
                    if (s_rlast) begin
                        s_arready <= 1'b1;
                        rd_state  <= RD_IDLE;
                    end else begin
                        rd_state <= RD_FETCH;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_host_mem_responder.sv
// tb_axi_host_mem_responder: directed self-checking bench for axi_host_mem_responder
module tb_axi_host_mem_responder;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   s_awid, s_bid, s_arid, s_rid;
    logic [63:0]  s_awaddr, s_araddr;
    logic [7:0]   s_awlen, s_arlen;
    logic         s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [511:0] s_wdata, s_rdata;
    logic [63:0]  s_wstrb;
    logic [1:0]   s_bresp, s_rresp;
    logic         s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    int           checks = 0;
    int           errors = 0;
    logic [511:0] rdat [8];
    logic [1:0]   rrsp [8];
    logic         rlst [8];
    logic [4:0]   bid;
    logic [1:0]   bresp;
    logic [511:0] exp_d, hi_d, lo_d;

    axi_host_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int k);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(k) * 32'h01000193 ^ 32'(i) * 32'h9E3779B9;
        return r;
    endfunction

    task automatic wr_burst(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int nb, input int k, input logic [63:0] strb,
                            output logic [4:0] b_id, output logic [1:0] b_resp);
        int n, st;
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
        n = 0;
        while (!s_awready && n < 20) begin @(negedge clk); n++; end
        check("aw_accept", s_awready, 1);
        @(negedge clk);
        s_awvalid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            s_wdata = pat(k + b); s_wstrb = strb; s_wlast = (b == nb - 1); s_wvalid = 1'b1;
            n = 0;
            while (!s_wready && n < 20) begin @(negedge clk); n++; end
            check("w_accept", s_wready, 1);
            @(negedge clk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        n = 0;
        while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
        check("b_valid", s_bvalid, 1);
        b_id = s_bid; b_resp = s_bresp;
        st = int'($urandom_range(0, 5));
        for (int i = 0; i < st; i++) begin
            @(negedge clk);
            check("b_stable", {s_bvalid, s_bid, s_bresp}, {1'b1, b_id, b_resp});
        end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        check("b_done", {s_bvalid, s_awready}, 2'b01);
    endtask

    task automatic rd_burst(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len);
        int n, st;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 20) begin @(negedge clk); n++; end
        check("ar_accept", s_arready, 1);
        @(negedge clk);
        s_arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
            check("r_latency", n, 1);
            check("r_id", s_rid, id);
            rdat[b] = s_rdata; rrsp[b] = s_rresp; rlst[b] = s_rlast;
            st = int'($urandom_range(0, 5));
            for (int i = 0; i < st; i++) begin
                @(negedge clk);
                check("r_stable_ctl", {s_rvalid, s_rlast, s_rresp, s_rid}, {1'b1, rlst[b], rrsp[b], id});
                check("r_stable_data", s_rdata, rdat[b]);
            end
            s_rready = 1'b1;
            @(negedge clk);
            s_rready = 1'b0;
        end
        check("r_done", {s_rvalid, s_arready}, 2'b01);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {s_awready, s_arready, s_wready}, 3'b110);
        check("rst_valid", {s_bvalid, s_rvalid, s_rlast}, 3'b000);
        check("rst_ids", {s_bid, s_rid, s_bresp, s_rresp}, 14'h0);
        check("rst_rdata", s_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        wr_burst(5'd3, 64'h80, 8'd3, 4, 0, '1, bid, bresp);
        check("t1_bid", bid, 5'd3);
        check("t1_bresp", bresp, 2'b00);
        rd_burst(5'd5, 64'h80, 8'd3);
        for (int b = 0; b < 4; b++) begin
            check("t1_rdata", rdat[b], pat(b));
            check("t1_rresp_rlast", {rrsp[b], rlst[b]}, {2'b00, b == 3});
        end

        wr_burst(5'd1, 64'h80, 8'd0, 1, 100, 64'hFF, bid, bresp);
        check("t2_bresp", bresp, 2'b00);
        rd_burst(5'd2, 64'h80, 8'd0);
        hi_d = pat(0); lo_d = pat(100);
        exp_d = {hi_d[511:64], lo_d[63:0]};
        check("t2_partial", rdat[0], exp_d);
        check("t2_rresp_rlast", {rrsp[0], rlst[0]}, 3'b001);

        wr_burst(5'd4, 64'hFFC0, 8'd0, 1, 200, '1, bid, bresp);
        check("t3_bresp", bresp, 2'b00);
        rd_burst(5'd6, 64'hFFC0, 8'd3);
        check("t3_b0_data", rdat[0], pat(200));
        check("t3_b0_resp", {rrsp[0], rlst[0]}, 3'b000);
        for (int b = 1; b < 4; b++) begin
            check("t3_oor_data", rdat[b], 0);
            check("t3_oor_resp", {rrsp[b], rlst[b]}, {2'b10, b == 3});
        end

        wr_burst(5'd7, 64'h200, 8'd3, 2, 300, '1, bid, bresp);
        check("t4_early_bid", bid, 5'd7);
        check("t4_early_bresp", bresp, 2'b10);
        wr_burst(5'd8, 64'h340, 8'd0, 1, 600, '1, bid, bresp);
        check("t4_next_bid", bid, 5'd8);
        check("t4_next_bresp", bresp, 2'b00);
        rd_burst(5'd9, 64'h200, 8'd1);
        check("t4_early_d0", rdat[0], pat(300));
        check("t4_early_d1", rdat[1], pat(301));

        wr_burst(5'd9, 64'h300, 8'd0, 2, 500, '1, bid, bresp);
        check("t5_long_bresp", bresp, 2'b10);
        rd_burst(5'd10, 64'h300, 8'd1);
        check("t5_long_d0", rdat[0], pat(500));
        check("t5_dropped_d1", rdat[1], pat(600));

        wr_burst(5'd10, 64'hFFC0, 8'd1, 2, 700, '1, bid, bresp);
        check("t6_cross_bresp", bresp, 2'b10);
        rd_burst(5'd11, 64'hFFC0, 8'd0);
        check("t6_cross_d0", rdat[0], pat(700));

        s_arid = 5'd12; s_araddr = 64'h80; s_arlen = 8'd3; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 20) begin @(negedge clk); n++; end
        check("t7_ar_accept", s_arready, 1);
        @(negedge clk);
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
        check("t7_rvalid", s_rvalid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t7_rst_ctl", {s_rvalid, s_arready, s_rlast, s_rid}, 8'b01000000);
        check("t7_rst_rdata", s_rdata, 0);
        @(negedge clk);
        rd_burst(5'd13, 64'h80, 8'd0);
        check("t7_after_data", rdat[0], exp_d);
        check("t7_after_resp", {rrsp[0], rlst[0]}, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
